// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: load/store unit after the execute ALU.
// Captures one operation at a time, runs a req/ack handshake to a
// variable-latency data memory, builds byte strobes / lane-replicated store
// data, and extracts + sign/zero-extends load data.
// Optional macro LSU_MISALIGN_TRAP_EN: misaligned accesses are not issued
// to memory; they complete immediately with misaligned=1 and rdata=0.
module lsu_mem_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  read_en,
    input  logic                  write_en,
    input  logic [1:0]            type_control,
    input  logic                  sign_ext,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_addr,
    output logic [STRB_WIDTH-1:0] mem_wstrb,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  misaligned
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] a_q, wd_q, rdata_q, load_ext;
    logic [1:0]            size_q;
    logic                  sext_q, we_q, mis_q;

    logic accept, access_in, mis_in, trap_in;

    assign accept    = (state == IDLE) && req_valid;
    assign access_in = read_en | write_en;
    // Byte accesses can never be misaligned; 11 behaves as word.
    assign mis_in    = ((type_control == 2'b01) && addr[0]) ||
                       (type_control[1] && (addr[1:0] != 2'b00));
`ifdef LSU_MISALIGN_TRAP_EN
    assign trap_in   = access_in & mis_in;
`else
    assign trap_in   = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state: no-ops and trapped accesses skip the memory phase
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_valid) state_nxt = (access_in && !trap_in) ? REQ : RESP;
            REQ:     if (mem_ack)   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        req_ready  = (state == IDLE);
        mem_req    = (state == REQ);
        rsp_valid  = (state == RESP);
        misaligned = (state == RESP) && mis_q;
    end

    // Capture the operation at acceptance; held stable through REQ
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            wd_q   <= '0;
            size_q <= 2'b00;
            sext_q <= 1'b0;
            we_q   <= 1'b0;
            mis_q  <= 1'b0;
        end else if (accept) begin
            a_q    <= addr;
            wd_q   <= wdata;
            size_q <= type_control;
            sext_q <= sign_ext;
            we_q   <= write_en;
            mis_q  <= access_in & mis_in;
        end
    end

    // Load lane select and extension; misaligned halves/words fall back to
    // the naturally aligned lane because only a[1] (half) or nothing (word) is used
    always_comb begin
        load_ext = mem_rdata;
        case (size_q)
            2'b00: begin
                case (a_q[1:0])
                    2'd0: load_ext = {{24{sext_q & mem_rdata[7]}},  mem_rdata[7:0]};
                    2'd1: load_ext = {{24{sext_q & mem_rdata[15]}}, mem_rdata[15:8]};
                    2'd2: load_ext = {{24{sext_q & mem_rdata[23]}}, mem_rdata[23:16]};
                    default: load_ext = {{24{sext_q & mem_rdata[31]}}, mem_rdata[31:24]};
                endcase
            end
            2'b01: begin
                if (a_q[1]) load_ext = {{16{sext_q & mem_rdata[31]}}, mem_rdata[31:16]};
                else        load_ext = {{16{sext_q & mem_rdata[15]}}, mem_rdata[15:0]};
            end
            default: load_ext = mem_rdata;
        endcase
    end

    // Result register: updated only on entry to RESP so it holds between responses
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            rdata_q <= '0;
        else if (accept && (state_nxt == RESP))
            rdata_q <= '0;
        else if ((state == REQ) && mem_ack)
            rdata_q <= we_q ? '0 : load_ext;
    end

    assign rdata    = rdata_q;
    assign mem_we   = we_q;
    assign mem_addr = {a_q[DATA_WIDTH-1:2], 2'b00};

    // Store lane strobes and replicated store data
    always_comb begin
        mem_wstrb = '0;
        mem_wdata = wd_q;
        case (size_q)
            2'b00: begin
                mem_wstrb = 4'b0001 << a_q[1:0];
                mem_wdata = {4{wd_q[7:0]}};
            end
            2'b01: begin
                mem_wstrb = a_q[1] ? 4'b1100 : 4'b0011;
                mem_wdata = {2{wd_q[15:0]}};
            end
            default: mem_wstrb = 4'b1111;
        endcase
        if (!we_q) mem_wstrb = '0;
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Bench for lsu_mem_stage: directed test-plan steps then randomized ops,
// checked against an arithmetic reference model of strobes, lane data and
// load extension.
module tb_lsu_mem_stage;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0, rst = 1'b1;
    logic        req_valid = 0, req_ready, read_en = 0, write_en = 0, sign_ext = 0;
    logic [1:0]  type_control = 2'b00;
    logic [31:0] addr = 0, wdata = 0, mem_addr, mem_wdata, mem_rdata = 0, rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_req, mem_we, mem_ack = 0, rsp_valid, misaligned;

    int total = 0, fails = 0;

    lsu_mem_stage dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .read_en(read_en), .write_en(write_en), .type_control(type_control),
        .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .mem_req(mem_req),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .rsp_valid(rsp_valid), .rdata(rdata), .misaligned(misaligned)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mis(input logic [1:0] ty, input logic [31:0] a);
        if (ty == 2'b00) return 1'b0;
        if (ty == 2'b01) return a[0];
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] ref_strb(input logic [1:0] ty, input logic [31:0] a);
        int unsigned lane = a % 4;
        if (ty == 2'b00) return 4'(1 << lane);
        if (ty == 2'b01) return (lane >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [1:0] ty, input logic [31:0] wd);
        if (ty == 2'b00) return (wd & 32'hFF) * 32'h0101_0101;
        if (ty == 2'b01) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] ty, input bit sx,
                                             input logic [31:0] a, input logic [31:0] m);
        logic [31:0] v;
        if (ty == 2'b00) begin
            v = (m >> (8 * (a % 4))) & 32'hFF;
            if (sx && v >= 128) v = v - 256;
        end else if (ty == 2'b01) begin
            v = (m >> (16 * ((a % 4) / 2))) & 32'hFFFF;
            if (sx && v >= 32768) v = v - 65536;
        end else v = m;
        return v;
    endfunction

    // One complete operation: present, accept, serve memory after lat extra
    // REQ cycles, then check the response pulse.
    task automatic do_op(input bit rd, input bit we, input logic [1:0] ty, input bit sx,
                         input logic [31:0] a, input logic [31:0] wd, input int lat,
                         input logic [31:0] mrd, input bit hold, input string tag);
        bit acc = rd | we;
        bit mis = acc && is_mis(ty, a);
        bit issue = acc && !(TRAP && mis);
        logic [31:0] er = (issue && !we) ? ref_load(ty, sx, a, mrd) : 32'h0;
        chk({tag, " ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1; read_en = rd; write_en = we; type_control = ty;
        sign_ext = sx; addr = a; wdata = wd;
        @(posedge clk); #1;
        if (!hold) req_valid = 0;
        if (issue) begin
            for (int k = 0; k <= lat; k++) begin
                chk({tag, " mem_req"}, 32'(mem_req), 32'd1);
                chk({tag, " ready_busy"}, 32'(req_ready), 32'd0);
                chk({tag, " mem_addr"}, mem_addr, a & 32'hFFFF_FFFC);
                chk({tag, " mem_we"}, 32'(mem_we), 32'(we));
                if (we) begin
                    chk({tag, " wstrb"}, 32'(mem_wstrb), 32'(ref_strb(ty, a)));
                    chk({tag, " wdata"}, mem_wdata, ref_wdata(ty, wd));
                end
                if (k == lat) begin mem_ack = 1; mem_rdata = mrd; end
                @(posedge clk); #1;
                mem_ack = 0; mem_rdata = $urandom;
            end
        end else begin
            chk({tag, " no_mem_req"}, 32'(mem_req), 32'd0);
        end
        chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, " rdata"}, rdata, er);
        chk({tag, " misaligned"}, 32'(misaligned), 32'(mis));
        chk({tag, " ready_resp"}, 32'(req_ready), 32'd0);
        req_valid = 0;
        @(posedge clk); #1;
        chk({tag, " rsp_done"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_done"}, 32'(mem_req), 32'd0);
        chk({tag, " rdata_hold"}, rdata, er);
    endtask

    initial begin
        logic [31:0] sweep [4];
        sweep = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_007F, 32'hFFFF_FF80};

        // Reset state
        #12;
        chk("rst req_ready", 32'(req_ready), 32'd1);
        chk("rst mem_req", 32'(mem_req), 32'd0);
        chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst rdata", rdata, 32'd0);
        chk("rst misaligned", 32'(misaligned), 32'd0);
        chk("rst mem_wstrb", 32'(mem_wstrb), 32'd0);
        @(negedge clk); rst = 0;
        @(posedge clk); #1;

        // Byte store, mem_req held two cycles
        do_op(0, 1, 2'b00, 0, 32'h1003, 32'h0000_00AB, 1, 32'h0, 0, "bstore");
        chk("bstore strb_const", 32'(ref_strb(2'b00, 32'h1003)), 32'h8);

        // Signed / unsigned half loads, same-cycle ack
        do_op(1, 0, 2'b01, 1, 32'h2002, 32'h0, 0, 32'h8001_1234, 0, "hload_s");
        do_op(1, 0, 2'b01, 0, 32'h2002, 32'h0, 0, 32'h8001_1234, 0, "hload_u");

        // Byte load sweep
        for (int i = 0; i < 4; i++) begin
            do_op(1, 0, 2'b00, 1, 32'h4000 + i, 32'h0, i % 2, 32'h807F_01FF, 0, "bsweep");
            chk("bsweep value", rdata, sweep[i]);
        end

        // Backpressure: req_valid held while REQ waits 5 cycles
        do_op(1, 0, 2'b10, 0, 32'h5000, 32'h0, 5, 32'h1234_5678, 1, "bp");

        // Misaligned word load
        do_op(1, 0, 2'b10, 0, 32'h3001, 32'h0, 1, 32'hCAFE_F00D, 0, "misw");
        // Store plus read_en: write takes priority
        do_op(1, 1, 2'b01, 1, 32'h6006, 32'h0000_BEEF, 2, 32'hFFFF_FFFF, 0, "rw_pri");
        // No enable: straight to RESP with rdata 0
        do_op(0, 0, 2'b10, 0, 32'h7000, 32'h0, 0, 32'h0, 0, "noop");
        do_op(1, 0, 2'b00, 1, 32'h7003, 32'h0, 0, 32'h8000_0000, 0, "preload");

        // Async reset mid-REQ
        req_valid = 1; read_en = 1; write_en = 0; type_control = 2'b10; addr = 32'h8000;
        @(posedge clk); #1;
        req_valid = 0;
        chk("rstmid mem_req_before", 32'(mem_req), 32'd1);
        #2 rst = 1;
        #1;
        chk("rstmid mem_req", 32'(mem_req), 32'd0);
        chk("rstmid rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid rdata", rdata, 32'd0);
        chk("rstmid req_ready", 32'(req_ready), 32'd1);
        @(negedge clk); rst = 0;
        mem_ack = 1; mem_rdata = 32'h1111_1111;
        @(posedge clk); #1;
        mem_ack = 0;
        chk("late_ack rsp_valid", 32'(rsp_valid), 32'd0);
        chk("late_ack mem_req", 32'(mem_req), 32'd0);
        @(posedge clk); #1;
        chk("late_ack rsp_valid2", 32'(rsp_valid), 32'd0);
        chk("late_ack rdata", rdata, 32'd0);

        // Randomized operations
        for (int n = 0; n < 60; n++) begin
            do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  $urandom, $urandom, $urandom_range(0, 3), $urandom,
                  1'($urandom_range(0, 1)), "rand");
        end

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
